// File: rtl/altpcie_av_cpl_err_pkg.sv
// Shared types and constants for the HIP completion-error arbiter.
// Contents: CPL_ERR_W, LTSSM_L0, the FSM state type, and a helper that maps a
// completion-error code to per-bit counter increments.
package altpcie_av_cpl_err_pkg;

  localparam int unsigned CPL_ERR_W = 7;
  localparam logic [4:0]  LTSSM_L0  = 5'h0F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Each set bit of a code bumps the counter of that bit by one.
  function automatic logic [CPL_ERR_W-1:0] cpl_err_bit_inc(input logic [CPL_ERR_W-1:0] code);
    return code;
  endfunction

endpackage

// File: rtl/altpcie_av_rr_arbiter.sv
// Round-robin arbiter: search starts at i_ptr, lowest index first from there.
// Ports:
//   i_req        request vector
//   i_ptr        current round-robin pointer
//   i_advance    a grant is being taken this cycle
//   o_grant_c    one-hot grant (combinational)
//   o_next_ptr_c winner+1 mod NUM_REQ when advancing, else i_ptr (combinational)
module altpcie_av_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant_c,
  output logic [PTR_W-1:0]   o_next_ptr_c
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;
  logic [PTR_W-1:0] w_win;

  // Rotating priority search plus pointer update.
  always_comb begin
    o_grant_c    = '0;
    o_next_ptr_c = i_ptr;
    w_found      = 1'b0;
    w_win        = '0;
    w_idx        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = PTR_W'((32'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    if (w_found) begin
      o_grant_c[w_win] = 1'b1;
    end
    if (i_advance && w_found) begin
      o_next_ptr_c = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + PTR_W'(1);
    end
  end

endmodule

// File: rtl/altpcie_av_cpl_err_arbiter.sv
// Shares the HIP cpl_err/cpl_pending interface among NUM_REQ requesters.
// Accepted codes are driven onto cpl_err for PULSE_CYCLES, followed by a
// GAP_CYCLES quiet period. Optional per-bit saturating error counters are
// built when CPL_ERR_CNT_EN is defined.
// Ports:
//   pld_clk, reset_status    clock, async active-high reset
//   ltssmstate               grants only while in L0
//   req_valid/req_err        per-requester code and valid
//   req_ready                one-hot accept strobe (combinational)
//   req_pending              per-requester completions outstanding
//   cpl_err, cpl_pending     to HIP
//   busy                     FSM not idle
//   err_cnt, err_cnt_clr     per-bit counters and clear (CPL_ERR_CNT_EN only)
module altpcie_av_cpl_err_arbiter
  import altpcie_av_cpl_err_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned PULSE_CYCLES = 1,
  parameter int unsigned GAP_CYCLES   = 2
`ifdef CPL_ERR_CNT_EN
 ,parameter int unsigned CNT_W        = 16
`endif
) (
  input  logic                           pld_clk,
  input  logic                           reset_status,
  input  logic [4:0]                     ltssmstate,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [CPL_ERR_W*NUM_REQ-1:0]   req_err,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_pending,
  output logic [CPL_ERR_W-1:0]           cpl_err,
  output logic                           cpl_pending,
`ifdef CPL_ERR_CNT_EN
  output logic [CPL_ERR_W*CNT_W-1:0]     err_cnt,
  input  logic                           err_cnt_clr,
`endif
  output logic                           busy
);

  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t                 r_state;
  logic [PTR_W-1:0]       r_ptr;
  logic [TMR_W-1:0]       r_tmr;
  logic [CPL_ERR_W-1:0]   r_cpl_err;
  logic                   r_busy;
  logic                   r_cpl_pending;

  logic [NUM_REQ-1:0]     w_grant;
  logic [PTR_W-1:0]       w_next_ptr;
  logic                   w_grant_en;
  logic                   w_accept;
  logic                   w_issue_start;
  logic [CPL_ERR_W-1:0]   w_code;

  // Ready is gated by reset too, so it reads 0 while reset is held.
  assign w_grant_en    = !reset_status && (r_state == IDLE) && (ltssmstate == LTSSM_L0);
  assign req_ready     = w_grant_en ? w_grant : '0;
  assign w_accept      = |req_ready;
  assign w_issue_start = w_accept && (w_code != '0);

  altpcie_av_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .i_req        (req_valid),
    .i_ptr        (r_ptr),
    .i_advance    (w_accept),
    .o_grant_c    (w_grant),
    .o_next_ptr_c (w_next_ptr)
  );

  // Code of the current round-robin winner.
  always_comb begin
    w_code = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_code = req_err[CPL_ERR_W*i +: CPL_ERR_W];
      end
    end
  end

  // Issue FSM: pulse the code, then hold cpl_err low for the gap.
  always_ff @(posedge pld_clk or posedge reset_status) begin
    if (reset_status) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_tmr     <= '0;
      r_cpl_err <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ptr <= w_next_ptr;
            // A zero code is consumed without touching the HIP.
            if (w_issue_start) begin
              r_state   <= ISSUE;
              r_cpl_err <= w_code;
              r_busy    <= 1'b1;
              r_tmr     <= '0;
            end
          end
        end
        ISSUE: begin
          if (r_tmr == PULSE_LAST) begin
            r_cpl_err <= '0;
            r_tmr     <= '0;
            if (GAP_CYCLES == 0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= GAP;
            end
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        GAP: begin
          if (r_tmr == GAP_LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_tmr   <= '0;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          r_cpl_err <= '0;
          r_busy    <= 1'b0;
          r_tmr     <= '0;
        end
      endcase
    end
  end

  // cpl_pending tracks the requesters regardless of FSM or link state.
  always_ff @(posedge pld_clk or posedge reset_status) begin
    if (reset_status) begin
      r_cpl_pending <= 1'b0;
    end else begin
      r_cpl_pending <= |req_pending;
    end
  end

  assign cpl_err     = r_cpl_err;
  assign cpl_pending = r_cpl_pending;
  assign busy        = r_busy;

`ifdef CPL_ERR_CNT_EN
  logic [CPL_ERR_W-1:0] w_inc;
  assign w_inc = w_issue_start ? cpl_err_bit_inc(w_code) : '0;

  // Saturating per-bit counters; clear wins over a same-cycle increment.
  for (genvar b = 0; b < CPL_ERR_W; b++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge pld_clk or posedge reset_status) begin
      if (reset_status) begin
        r_cnt <= '0;
      end else if (err_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_inc[b] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
    assign err_cnt[CNT_W*b +: CNT_W] = r_cnt;
  end
`endif

endmodule

// File: tb/tb_altpcie_av_cpl_err_arbiter.sv
// Self-checking bench for altpcie_av_cpl_err_arbiter (NUM_REQ=4, PULSE=1, GAP=2).
// Counter checks are built when CPL_ERR_CNT_EN is defined (CNT_W=2).
module tb_altpcie_av_cpl_err_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned CW = 2;

  logic          pld_clk;
  logic          reset_status;
  logic [4:0]    ltssmstate;
  logic [NR-1:0] req_valid;
  logic [7*NR-1:0] req_err;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] req_pending;
  logic [6:0]    cpl_err;
  logic          cpl_pending;
  logic          busy;
`ifdef CPL_ERR_CNT_EN
  logic [7*CW-1:0] err_cnt;
  logic            err_cnt_clr;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] exp_q[$];
  logic [6:0] obs_q[$];
  int         gnt_q[$];

  altpcie_av_cpl_err_arbiter #(
    .NUM_REQ      (NR),
    .PULSE_CYCLES (1),
    .GAP_CYCLES   (2)
`ifdef CPL_ERR_CNT_EN
   ,.CNT_W        (CW)
`endif
  ) dut (
    .pld_clk      (pld_clk),
    .reset_status (reset_status),
    .ltssmstate   (ltssmstate),
    .req_valid    (req_valid),
    .req_err      (req_err),
    .req_ready    (req_ready),
    .req_pending  (req_pending),
    .cpl_err      (cpl_err),
    .cpl_pending  (cpl_pending),
`ifdef CPL_ERR_CNT_EN
    .err_cnt      (err_cnt),
    .err_cnt_clr  (err_cnt_clr),
`endif
    .busy         (busy)
  );

  initial begin
    pld_clk = 1'b0;
    forever #5 pld_clk = ~pld_clk;
  end

  // Sample at the falling edge; log observed pulses and grants.
  task automatic sample();
    @(negedge pld_clk);
    if (cpl_err != 7'h00) obs_q.push_back(cpl_err);
    for (int i = 0; i < NR; i++) if (req_ready[i]) gnt_q.push_back(i);
  endtask

  task automatic adv();
    @(posedge pld_clk);
    #1;
  endtask

  task automatic set_code(input int idx, input logic [6:0] code);
    req_err[7*idx +: 7] = code;
  endtask

  task automatic apply_reset();
    reset_status = 1'b1;
    ltssmstate   = 5'h0F;
    req_valid    = '0;
    req_err      = '0;
    req_pending  = '0;
`ifdef CPL_ERR_CNT_EN
    err_cnt_clr  = 1'b0;
`endif
    repeat (2) adv();
    reset_status = 1'b0;
    exp_q.delete();
    obs_q.delete();
    gnt_q.delete();
  endtask

  task automatic test_reset();
    reset_status = 1'b1;
    ltssmstate   = 5'h0F;
    req_valid    = 4'hF;
    req_err      = {7'h08, 7'h04, 7'h02, 7'h01};
    req_pending  = 4'hF;
    @(negedge pld_clk);
    n_tests++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL rst_ready: got %b required 0000", req_ready); end
    n_tests++; if (cpl_err !== 7'h00) begin n_fail++; $display("FAIL rst_cpl_err: got %h required 00", cpl_err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_tests++; if (cpl_pending !== 1'b0) begin n_fail++; $display("FAIL rst_cpl_pending: got %b required 0", cpl_pending); end
    apply_reset();
  endtask

  task automatic test_single();
    logic [6:0] e_err;
    apply_reset();
    set_code(0, 7'h04);
    req_valid = 4'b0001;
    exp_q.push_back(7'h04);
    sample();
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b required 0001", req_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy0: got %b required 0", busy); end
    adv();
    req_valid = '0;
    for (int c = 1; c <= 4; c++) begin
      sample();
      e_err = (c == 1) ? 7'h04 : 7'h00;
      n_tests++; if (cpl_err !== e_err) begin n_fail++; $display("FAIL single_err_c%0d: got %h required %h", c, cpl_err, e_err); end
      n_tests++; if (busy !== (c <= 3)) begin n_fail++; $display("FAIL single_busy_c%0d: got %b required %b", c, busy, (c <= 3)); end
      adv();
    end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_sb_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_sb_%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_round_robin();
    int gcyc[$];
    int e_gnt[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    set_code(0, 7'h01); set_code(1, 7'h02); set_code(2, 7'h04); set_code(3, 7'h08);
    req_valid = 4'b1111;
    foreach (e_gnt[i]) exp_q.push_back(7'h01 << e_gnt[i]);
    for (int c = 0; c <= 16; c++) begin
      sample();
      if (req_ready != 4'h0) gcyc.push_back(c);
      adv();
    end
    req_valid = '0;
    repeat (4) begin sample(); adv(); end
    n_tests++;
    if (gnt_q.size() != 5 || gcyc.size() != 5) begin
      n_fail++; $display("FAIL rr_grant_count: got %0d required 5", gnt_q.size());
    end else begin
      foreach (e_gnt[i]) begin
        n_tests++; if (gnt_q[i] != e_gnt[i]) begin n_fail++; $display("FAIL rr_grant_%0d: got %0d required %0d", i, gnt_q[i], e_gnt[i]); end
        n_tests++; if (gcyc[i] != 4*i) begin n_fail++; $display("FAIL rr_spacing_%0d: got cycle %0d required %0d", i, gcyc[i], 4*i); end
      end
    end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rr_sb_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rr_sb_%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_ltssm();
    int bad = 0;
    apply_reset();
    ltssmstate = 5'h11;
    set_code(0, 7'h02);
    req_valid = 4'b0001;
    repeat (20) begin
      sample();
      if (req_ready != 4'h0 || cpl_err != 7'h00 || busy) bad++;
      adv();
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL ltssm_hold: got %0d bad cycles required 0", bad); end
    ltssmstate = 5'h0F;
    exp_q.push_back(7'h02);
    sample();
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL ltssm_grant: got %b required 0001", req_ready); end
    adv();
    req_valid  = '0;
    ltssmstate = 5'h11;
    sample();
    n_tests++; if (cpl_err !== 7'h02) begin n_fail++; $display("FAIL ltssm_issue: got %h required 02", cpl_err); end
    adv();
    sample();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ltssm_gap_busy: got %b required 1", busy); end
    adv(); adv();
    sample();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ltssm_done_busy: got %b required 0", busy); end
    ltssmstate = 5'h0F;
    adv();
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ltssm_sb_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ltssm_sb_%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_zero_code();
    apply_reset();
    set_code(2, 7'h00);
    set_code(3, 7'h10);
    req_valid = 4'b1100;
    sample();
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL zero_ready2: got %b required 0100", req_ready); end
    adv();
    req_valid = 4'b1000;
    exp_q.push_back(7'h10);
    sample();
    n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL zero_ready3: got %b required 1000", req_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b required 0", busy); end
    n_tests++; if (cpl_err !== 7'h00) begin n_fail++; $display("FAIL zero_cpl_err: got %h required 00", cpl_err); end
    adv();
    req_valid = '0;
    sample();
    n_tests++; if (cpl_err !== 7'h10) begin n_fail++; $display("FAIL zero_next_issue: got %h required 10", cpl_err); end
    adv();
    repeat (3) begin sample(); adv(); end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL zero_sb_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL zero_sb_%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_code(1, 7'h20);
    req_valid = 4'b0010;
    sample();
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rmid_ready: got %b required 0010", req_ready); end
    adv();
    req_valid = '0;
    sample();
    n_tests++; if (cpl_err !== 7'h20) begin n_fail++; $display("FAIL rmid_issue: got %h required 20", cpl_err); end
    #1 reset_status = 1'b1;
    #1;
    n_tests++; if (cpl_err !== 7'h00) begin n_fail++; $display("FAIL rmid_async_err: got %h required 00", cpl_err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_async_busy: got %b required 0", busy); end
    adv(); adv();
    reset_status = 1'b0;
    obs_q.delete();
    gnt_q.delete();
    set_code(0, 7'h01); set_code(1, 7'h02); set_code(2, 7'h04); set_code(3, 7'h08);
    req_valid = 4'b1111;
    exp_q.push_back(7'h01);
    sample();
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_ptr_restored: got %b required 0001", req_ready); end
    adv();
    req_valid   = '0;
    req_pending = 4'b0100;
    sample();
    n_tests++; if (cpl_pending !== 1'b0) begin n_fail++; $display("FAIL pend_latency0: got %b required 0", cpl_pending); end
    adv();
    sample();
    n_tests++; if (cpl_pending !== 1'b1) begin n_fail++; $display("FAIL pend_latency1: got %b required 1", cpl_pending); end
    adv();
    req_pending = '0;
    repeat (3) begin sample(); adv(); end
    n_tests++; if (cpl_pending !== 1'b0) begin n_fail++; $display("FAIL pend_clear: got %b required 0", cpl_pending); end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rmid_sb_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_sb_%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

`ifdef CPL_ERR_CNT_EN
  task automatic test_counters();
    logic [7*CW-1:0] e_cnt;
    apply_reset();
    set_code(0, 7'h05);
    repeat (5) begin
      req_valid = 4'b0001;
      exp_q.push_back(7'h05);
      sample(); adv();
      req_valid = '0;
      repeat (3) begin sample(); adv(); end
    end
    // Bit 0 and bit 2 each saw five increments and stick at 2'b11.
    e_cnt = '0;
    e_cnt[1:0] = 2'b11;
    e_cnt[5:4] = 2'b11;
    n_tests++; if (err_cnt !== e_cnt) begin n_fail++; $display("FAIL cnt_saturate: got %h required %h", err_cnt, e_cnt); end
    req_valid   = 4'b0001;
    err_cnt_clr = 1'b1;
    exp_q.push_back(7'h05);
    sample(); adv();
    req_valid   = '0;
    err_cnt_clr = 1'b0;
    sample();
    n_tests++; if (err_cnt !== '0) begin n_fail++; $display("FAIL cnt_clr_priority: got %h required 0", err_cnt); end
    adv();
    repeat (3) begin sample(); adv(); end
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL cnt_sb_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL cnt_sb_%0d: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask
`endif

  initial begin
    reset_status = 1'b1;
    ltssmstate   = 5'h0F;
    req_valid    = '0;
    req_err      = '0;
    req_pending  = '0;
`ifdef CPL_ERR_CNT_EN
    err_cnt_clr  = 1'b0;
`endif
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_ltssm();
    test_zero_code();
    test_reset_mid();
`ifdef CPL_ERR_CNT_EN
    test_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
